// File: rtl/pc_next_sequencer.sv
// Next-PC generator for the fetch stage. It picks one of four next fetch addresses:
// sequential, hold, EX-stage redirect, or the reset vector.
// A redirect that arrives during a stall is parked until the stall releases.
// The block also raises the IF/ID valid and flush controls.
module pc_next_sequencer #(
    parameter int unsigned XLEN = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned INSN_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_current,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_next,
    output logic            fetch_valid,
    output logic            flush,
    output logic            misaligned,
    output logic [31:0]     redirect_count
);

    // Low address bits that must be zero for an instruction-aligned fetch.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSN_BYTES - 32'd1);
    localparam logic [XLEN-1:0] INCR     = XLEN'(INSN_BYTES);
    localparam logic [31:0]     CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        PEND = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            misaligned_q, misaligned_d;
    logic [31:0]     redirect_count_q, redirect_count_d;

    logic [XLEN-1:0] aligned_target_s;
    logic            target_misaligned_s;
    logic            redirect_accept_s;

    // Force the low alignment bits of a redirect target to zero.
    function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    // Return 1 when any alignment bit of the address is set.
    function automatic logic low_bits_set(input logic [XLEN-1:0] addr);
        return |(addr & LOW_MASK);
    endfunction

    // Increment the counter, but stop once it reaches all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        logic [31:0] res;
        if (val == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

    assign aligned_target_s    = align_addr(redirect_target);
    assign target_misaligned_s = low_bits_set(redirect_target);
    // BOOT ignores redirects entirely. Every other state accepts and counts them.
    assign redirect_accept_s   = redirect_valid && (state_q != BOOT);

    // Decode the next PC, the pipeline controls and the next state.
    always_comb begin
        state_d          = state_q;
        pend_target_d    = pend_target_q;
        misaligned_d     = misaligned_q;
        redirect_count_d = redirect_count_q;
        pc_next          = pc_current;
        fetch_valid      = 1'b0;
        flush            = 1'b0;

        case (state_q)
            BOOT: begin
                // Fetch the reset vector whatever the PC register currently holds.
                pc_next = RESET_VECTOR;
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (redirect_valid && !stall) begin
                    pc_next = aligned_target_s;
                    flush   = 1'b1;
                    state_d = RUN;
                end else if (redirect_valid && stall) begin
                    // Kill the wrong-path work now, then apply the target once the stall clears.
                    pend_target_d = aligned_target_s;
                    flush         = 1'b1;
                    state_d       = PEND;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    pc_next     = pc_current + INCR;
                    fetch_valid = 1'b1;
                    state_d     = RUN;
                end
            end
            PEND: begin
                if (stall) begin
                    if (redirect_valid) begin
                        // A younger redirect replaces the parked one.
                        pend_target_d = aligned_target_s;
                        flush         = 1'b1;
                    end else begin
                        pend_target_d = pend_target_q;
                    end
                end else begin
                    if (redirect_valid) begin
                        pc_next = aligned_target_s;
                        flush   = 1'b1;
                    end else begin
                        pc_next = pend_target_q;
                    end
                    state_d = RUN;
                end
            end
            default: begin
                pc_next = RESET_VECTOR;
                state_d = BOOT;
            end
        endcase

        if (redirect_accept_s) begin
            redirect_count_d = sat_inc(redirect_count_q);
            misaligned_d     = misaligned_q | target_misaligned_s;
        end else begin
            redirect_count_d = redirect_count_q;
            misaligned_d     = misaligned_q;
        end
    end

    // State registers. Reset throws away any parked redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= BOOT;
            pend_target_q    <= {XLEN{1'b0}};
            misaligned_q     <= 1'b0;
            redirect_count_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            pend_target_q    <= pend_target_d;
            misaligned_q     <= misaligned_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign misaligned     = misaligned_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Directed bench for pc_next_sequencer. A behavioural model predicts every output on every cycle.
// Literal expectations pin the model at the key points.
module tb_pc_next_sequencer;

    logic        clk;
    logic        reset;
    logic [63:0] pc_current;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] pc_next;
    logic        fetch_valid;
    logic        flush;
    logic        misaligned;
    logic [31:0] redirect_count;

    pc_next_sequencer #(
        .XLEN(64),
        .RESET_VECTOR(64'h0),
        .INSN_BYTES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_current(pc_current),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .pc_next(pc_next),
        .fetch_valid(fetch_valid),
        .flush(flush),
        .misaligned(misaligned),
        .redirect_count(redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model. It loads the predicted pc_next unless the stimulus overrides it.
    logic [63:0] pc_reg;
    logic        pc_ovr_en;
    logic [63:0] pc_ovr_val;
    assign pc_current = pc_ovr_en ? pc_ovr_val : pc_reg;

    // Model state. Mode 0 is the boot cycle, 1 is normal fetch, 2 is a parked redirect.
    int          m_mode;
    logic [63:0] m_pend;
    logic        m_mis;
    logic [31:0] m_cnt;
    logic        preset_pulse;
    logic [31:0] preset_val;

    logic [63:0] e_pc;
    logic        e_fv;
    logic        e_fl;
    logic [63:0] aligned;
    logic        accept;

    assign aligned = redirect_target - (redirect_target % 64'd4);
    assign accept  = redirect_valid && (m_mode != 0);

    // Expected combinational outputs, derived from the rules for each mode.
    always_comb begin
        e_pc = pc_current;
        e_fv = 1'b0;
        e_fl = 1'b0;
        if (m_mode == 0) begin
            e_pc = 64'h0;
        end else if (redirect_valid && !stall) begin
            e_pc = aligned;
            e_fl = 1'b1;
        end else if (redirect_valid && stall) begin
            e_fl = 1'b1;
        end else if (stall) begin
            e_pc = pc_current;
        end else if (m_mode == 2) begin
            e_pc = m_pend;
        end else begin
            e_pc = pc_current + 64'd4;
            e_fv = 1'b1;
        end
    end

    // Advance the model state at each clock edge.
    always @(posedge clk or posedge reset) begin
        logic [32:0] sum;
        if (reset) begin
            m_mode <= 0;
            m_pend <= 64'h0;
            m_mis  <= 1'b0;
            m_cnt  <= 32'h0;
        end else begin
            sum = {1'b0, (preset_pulse ? preset_val : m_cnt)} + {32'h0, accept};
            m_cnt <= (sum > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            m_mis <= m_mis | (accept && ((redirect_target % 64'd4) != 64'd0));
            if (accept && stall) m_pend <= aligned;
            if (m_mode == 0) m_mode <= 1;
            else if (m_mode == 1) m_mode <= (redirect_valid && stall) ? 2 : 1;
            else m_mode <= stall ? 2 : 1;
        end
    end

    // Load the modelled PC register with the predicted next PC.
    always @(posedge clk) pc_reg <= e_pc;

    // Literal expectation slot. The stimulus fills it and the compare process checks it.
    int          lit_sel;
    logic [63:0] lit_exp;
    string       lit_name;

    int n_vec;
    int n_bad;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process. It checks every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [63:0] pick;
        check("pc_next", pc_next, e_pc);
        check("fetch_valid", {63'h0, fetch_valid}, {63'h0, e_fv});
        check("flush", {63'h0, flush}, {63'h0, e_fl});
        check("misaligned", {63'h0, misaligned}, {63'h0, m_mis});
        if (!preset_pulse) check("redirect_count", {32'h0, redirect_count}, {32'h0, m_cnt});
        if (lit_sel != 0) begin
            case (lit_sel)
                1: pick = pc_next;
                2: pick = {63'h0, fetch_valid};
                3: pick = {63'h0, flush};
                4: pick = {63'h0, misaligned};
                5: pick = {32'h0, redirect_count};
                default: pick = 64'h0;
            endcase
            check(lit_name, pick, lit_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_sel = 0;
        preset_pulse = 1'b0;
    endtask

    task automatic lit(input int sel, input logic [63:0] exp, input string nm);
        lit_sel  = sel;
        lit_exp  = exp;
        lit_name = nm;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        lit_sel = 0;
        lit_exp = 64'h0;
        lit_name = "";
        preset_pulse = 1'b0;
        preset_val = 32'h0;
        reset = 1'b1;
        pc_ovr_en = 1'b1;
        pc_ovr_val = 64'h40;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 64'h0;

        // 1: reset, boot cycle, then sequential fetch
        tick();
        lit(1, 64'h0, "reset_pc");
        tick();
        reset = 1'b0;
        lit(2, 64'h0, "boot_fetch_valid");
        tick();
        pc_ovr_en = 1'b0;
        lit(1, 64'h4, "seq_4");
        tick();
        lit(1, 64'h8, "seq_8");
        tick();
        lit(1, 64'hC, "seq_12");
        tick();

        // 2: redirect while running
        pc_ovr_en = 1'b1;
        pc_ovr_val = 64'h100;
        redirect_valid = 1'b1;
        redirect_target = 64'h2000;
        lit(1, 64'h2000, "redirect_pc");
        tick();
        pc_ovr_en = 1'b0;
        redirect_valid = 1'b0;
        lit(1, 64'h2004, "after_redirect_pc");
        tick();
        lit(5, 64'h1, "redirect_count_1");
        tick();

        // 3: redirect during a stall is parked
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 64'h300;
        lit(3, 64'h1, "pend_flush_first");
        tick();
        redirect_valid = 1'b0;
        lit(3, 64'h0, "pend_flush_second");
        tick();
        lit(1, 64'h2008, "pend_hold_pc");
        tick();
        stall = 1'b0;
        lit(1, 64'h300, "pend_release_pc");
        tick();
        lit(1, 64'h304, "post_pend_pc");
        tick();

        // 4: misaligned target, sticky flag, cleared by reset
        redirect_valid = 1'b1;
        redirect_target = 64'h1006;
        lit(1, 64'h1004, "misalign_pc");
        tick();
        redirect_valid = 1'b0;
        lit(4, 64'h1, "misaligned_set");
        for (int i = 0; i < 10; i++) tick();
        lit(4, 64'h1, "misaligned_sticky");
        tick();
        reset = 1'b1;
        lit(4, 64'h0, "misaligned_reset");
        tick();
        reset = 1'b0;
        tick();

        // 5: address wrap, then counter saturation from a preset value
        pc_ovr_en = 1'b1;
        pc_ovr_val = 64'hFFFF_FFFF_FFFF_FFFC;
        lit(1, 64'h0, "wrap_pc");
        tick();
        pc_ovr_en = 1'b0;
        preset_val = 32'hFFFF_FFFA;
        preset_pulse = 1'b1;
        force dut.redirect_count_q = 32'hFFFF_FFFA;
        #1;
        release dut.redirect_count_q;
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h800;
        for (int i = 0; i < 8; i++) tick();
        redirect_valid = 1'b0;
        lit(5, 64'hFFFF_FFFF, "count_saturated");
        tick();
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        lit(5, 64'hFFFF_FFFF, "count_hold");
        tick();

        // 6: reset while a redirect is parked drops it
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 64'h500;
        tick();
        redirect_valid = 1'b0;
        tick();
        reset = 1'b1;
        lit(1, 64'h0, "pend_reset_pc");
        tick();
        tick();
        reset = 1'b0;
        stall = 1'b0;
        lit(1, 64'h0, "post_reset_boot_pc");
        tick();
        lit(1, 64'h4, "post_reset_seq_pc");
        for (int i = 0; i < 5; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
